// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md : base ALU plus iterative RISC-V M-extension multiply/divide unit.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready high only in IDLE)
//   md_sel            0 = base ALU op (Operation), 1 = mul/div op (md_op)
//   Operation         base op selector (encodings below)
//   md_op             RISC-V M funct3 (MUL..REMU)
//   SrcA, SrcB        operands
//   flush             abort any in-flight or held operation
//   out_valid/out_ready result handshake, ALUResult registered result
//   busy              high while the mul/div engine iterates
//
// Base ops finish one cycle after acceptance. Mul/div ops run WIDTH
// iterations of a shared radix-2 engine on operand magnitudes; signs are
// re-applied on the final iteration.
// -----------------------------------------------------------------------------
module alu_md #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             md_sel,
   input  logic [3:0]       Operation,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             busy
);

   // aluOpType encodings
   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,
                          OP_OR  = 4'd3,  OP_AND = 4'd4,  OP_SLL = 4'd5,
                          OP_SRL = 4'd6,  OP_SRA = 4'd7,  OP_EQUAL = 4'd8,
                          OP_NEQUAL = 4'd9, OP_LT = 4'd10, OP_GT = 4'd11,
                          OP_LTU = 4'd12, OP_GTU = 4'd13, OP_BPS2 = 4'd14;

   localparam logic [2:0] MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_DIV = 3'd4,
                          MD_REM = 3'd6;

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q, b_q, res_q;
   logic               qneg_q, rneg_q;

   // ---------------- base ALU (evaluated on the request inputs) ------------
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   base_res;

   always_comb begin
      shamt    = SrcB[SHAMT_W-1:0];
      base_res = '0;
      case (Operation)
         OP_ADD:    base_res = SrcA + SrcB;
         OP_SUB:    base_res = SrcA - SrcB;
         OP_XOR:    base_res = SrcA ^ SrcB;
         OP_OR:     base_res = SrcA | SrcB;
         OP_AND:    base_res = SrcA & SrcB;
         OP_SLL:    base_res = SrcA << shamt;
         OP_SRL:    base_res = SrcA >> shamt;
         OP_SRA:    base_res = $signed(SrcA) >>> shamt;
         OP_EQUAL:  base_res = {{(WIDTH-1){1'b0}}, SrcA == SrcB};
         OP_NEQUAL: base_res = {{(WIDTH-1){1'b0}}, SrcA != SrcB};
         OP_LT:     base_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) <  $signed(SrcB)};
         OP_GT:     base_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) >= $signed(SrcB)};
         OP_LTU:    base_res = {{(WIDTH-1){1'b0}}, SrcA <  SrcB};
         OP_GTU:    base_res = {{(WIDTH-1){1'b0}}, SrcA >= SrcB};
         OP_BPS2:   base_res = SrcB;
         default:   base_res = '0;
      endcase
   end

   // ---------------- operand preparation for mul/div ------------------------
   logic             a_sgn, b_sgn, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      a_sgn  = (md_op == MD_MULH) || (md_op == MD_MULHSU) ||
               (md_op == MD_DIV)  || (md_op == MD_REM);
      b_sgn  = (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
      a_neg  = a_sgn & SrcA[WIDTH-1];
      b_neg  = b_sgn & SrcB[WIDTH-1];
      b_zero = (SrcB == '0);
      a_mag  = a_neg ? -SrcA : SrcA;
      b_mag  = b_neg ? -SrcB : SrcB;
   end

   // ---------------- one radix-2 iteration ----------------------------------
   // Multiply: {hi,lo} holds partial product / remaining multiplier bits.
   // Divide (restoring): hi is the partial remainder, lo shifts the dividend
   // out at the top and the quotient bits in at the bottom.
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [WIDTH-1:0]   hi_d, lo_d, quo, rem;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   md_res;

   always_comb begin
      mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      if (op_q[2]) begin
         if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      prod   = {hi_d, lo_d};
      prod_s = qneg_q ? -prod : prod;
      quo    = qneg_q ? -lo_d : lo_d;
      rem    = rneg_q ? -hi_d : hi_d;
      if (op_q[2])
         md_res = op_q[1] ? rem : quo;
      else
         md_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
   end

   // ---------------- control FSM --------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               if (md_sel) begin
                  op_q    <= md_op;
                  cnt_q   <= '0;
                  hi_q    <= '0;
                  lo_q    <= a_mag;
                  b_q     <= b_mag;
                  // divide by zero keeps the all-ones quotient unsigned
                  qneg_q  <= md_op[2] ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);
                  rneg_q  <= a_neg;
                  state_q <= BUSY;
               end else begin
                  res_q   <= base_res;
                  state_q <= DONE;
               end
            end
            BUSY: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  res_q   <= md_res;
                  state_q <= DONE;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   assign ALUResult = res_q;

endmodule

// File: tb/tb_alu_md.sv
// -----------------------------------------------------------------------------
// tb_alu_md : scoreboard bench for alu_md (WIDTH=32). The driver pushes the
// expected result and arrival cycle; a negedge monitor checks latency,
// result, hold stability and in_ready while a result is presented.
// -----------------------------------------------------------------------------
module tb_alu_md;
   localparam int W = 32;

   localparam logic [3:0] ADD = 0, SUB = 1, XOR_ = 2, OR_ = 3, AND_ = 4, SLL = 5,
                          SRL = 6, SRA = 7, EQUAL = 8, NEQUAL = 9, LT = 10,
                          GT = 11, LTU = 12, GTU = 13, BPS2 = 14;

   logic         clk = 0, reset = 1, in_valid = 0, md_sel = 0, flush = 0, out_ready = 1;
   logic [3:0]   Operation = 0;
   logic [2:0]   md_op = 0;
   logic [W-1:0] SrcA = 0, SrcB = 0;
   logic         in_ready, out_valid, busy;
   logic [W-1:0] ALUResult;

   alu_md #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .md_sel(md_sel), .Operation(Operation), .md_op(md_op), .SrcA(SrcA),
      .SrcB(SrcB), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .ALUResult(ALUResult), .busy(busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [W-1:0] res; int due; } exp_t;
   exp_t q[$];

   int checks = 0, failures = 0;
   int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit arithmetic straight from the op definitions.
   function automatic logic [W-1:0] model(bit msel, logic [3:0] op, logic [2:0] mop,
                                          logic [W-1:0] a, logic [W-1:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] up;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = a;
      ib = b;
      if (!msel) begin
         case (op)
            ADD:    return a + b;
            SUB:    return a - b;
            XOR_:   return a ^ b;
            OR_:    return a | b;
            AND_:   return a & b;
            SLL:    return a << b[4:0];
            SRL:    return a >> b[4:0];
            SRA:    return W'(sa >>> b[4:0]);
            EQUAL:  return (a == b) ? 1 : 0;
            NEQUAL: return (a != b) ? 1 : 0;
            LT:     return (sa < sb) ? 1 : 0;
            GT:     return (sa >= sb) ? 1 : 0;
            LTU:    return (a < b) ? 1 : 0;
            GTU:    return (a >= b) ? 1 : 0;
            BPS2:   return b;
            default: return 0;
         endcase
      end
      case (mop)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == '1) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == '1) return 0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic issue(bit msel, logic [3:0] op, logic [2:0] mop, logic [W-1:0] a,
                        logic [W-1:0] b, logic [W-1:0] exp, bit push);
      int n = 0;
      while (!in_ready && n < 500) begin @(negedge clk); n++; end
      if (!in_ready) begin
         chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
         return;
      end
      md_sel = msel; Operation = op; md_op = mop; SrcA = a; SrcB = b; in_valid = 1;
      if (push) q.push_back('{exp, cyc + 1 + (msel ? W : 0)});
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic run(bit msel, logic [3:0] op, logic [2:0] mop, logic [W-1:0] a,
                      logic [W-1:0] b, logic [W-1:0] exp);
      issue(msel, op, mop, a, b, exp, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
      if (q.size() != 0) begin
         chk("drain_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 1;
         default: return $urandom;
      endcase
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1;
         1: out_ready = $urandom_range(0, 1);
         default: out_ready = 0;
      endcase
   end

   // Monitor
   bit           hold = 0, seen = 0;
   logic [W-1:0] hold_res = 0;
   always @(negedge clk) begin
      if (reset) begin
         hold = 0;
         seen = 0;
      end else begin
         if (hold) begin
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_result", ALUResult, hold_res);
         end
         if (out_valid) begin
            chk("in_ready_while_valid", {63'b0, in_ready}, 64'd0);
            if (q.size() == 0) begin
               chk("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
               if (!seen) begin
                  chk("latency", 64'(cyc), 64'(q[0].due));
                  seen = 1;
               end
               if (out_ready) begin
                  chk("result", ALUResult, q[0].res);
                  void'(q.pop_front());
                  seen = 0;
               end
            end
         end
         hold     = out_valid && !out_ready;
         hold_res = ALUResult;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_result", ALUResult, 64'd0);

      // Directed values
      run(0, ADD, 0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
      run(0, SRA, 0, 32'h8000_0000, 32'd35, 32'hF000_0000);
      run(0, SUB, 0, 32'h0, 32'h1, 32'hFFFF_FFFF);
      run(0, LT, 0, 32'hFFFF_FFFF, 32'h1, 32'h1);
      run(0, LTU, 0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      run(0, GT, 0, 32'h5, 32'h5, 32'h1);
      run(0, BPS2, 0, 32'h1234, 32'hABCD, 32'hABCD);
      run(0, 4'd15, 0, 32'h1234, 32'hABCD, 32'h0);
      run(1, 0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      chk("busy_after_md_accept", {63'b0, busy}, 64'd1);
      run(1, 0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run(1, 0, 3'd0, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB);
      run(1, 0, 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
      run(1, 0, 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
      run(1, 0, 3'd5, 32'h5, 32'h0, 32'hFFFF_FFFF);
      run(1, 0, 3'd7, 32'h5, 32'h0, 32'h5);
      run(1, 0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run(1, 0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      run(1, 0, 3'd4, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF);
      run(1, 0, 3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9);
      wait_drain();

      // Back-pressure: result held while out_ready is low
      ready_mode = 2;
      @(negedge clk);
      run(0, ADD, 0, 32'd3, 32'd4, 32'd7);
      repeat (6) @(negedge clk);
      ready_mode = 0;
      wait_drain();
      @(negedge clk);
      chk("idle_after_release", {63'b0, in_ready}, 64'd1);

      // Flush beats acceptance in the same cycle
      md_sel = 0; Operation = ADD; SrcA = 1; SrcB = 1; in_valid = 1; flush = 1;
      @(negedge clk);
      in_valid = 0; flush = 0;
      chk("flush_vs_accept_valid", {63'b0, out_valid}, 64'd0);
      chk("flush_vs_accept_ready", {63'b0, in_ready}, 64'd1);

      // Flush mid-DIVU
      issue(1, 0, 3'd5, 32'd1000, 32'd7, 0, 0);
      repeat (9) @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0;
      chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
      chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
      chk("flush_busy", {63'b0, busy}, 64'd0);
      repeat (W + 5) @(negedge clk);

      // Reset mid-DIVU
      issue(1, 0, 3'd5, 32'd999, 32'd3, 0, 0);
      repeat (4) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_result", ALUResult, 64'd0);
      repeat (W + 5) @(negedge clk);

      // Randomized traffic with random back-pressure
      ready_mode = 1;
      for (int i = 0; i < 250; i++) begin
         bit           msel;
         logic [3:0]   op;
         logic [2:0]   mop;
         logic [W-1:0] a, b;
         msel = ($urandom_range(0, 2) == 0);
         op   = 4'($urandom_range(0, 15));
         mop  = 3'($urandom_range(0, 7));
         a    = rnd_operand();
         b    = rnd_operand();
         run(msel, op, mop, a, b, model(msel, op, mop, a, b));
      end
      ready_mode = 0;
      wait_drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
